// File: rtl/reg_dump_uart.sv
// reg_dump_uart: on a trigger pulse, snapshots the packed GPR debug bus and
// streams a header byte followed by every register byte (LSB-first) on an
// 8N1 UART line with no idle gap between bytes.
module reg_dump_uart #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         NUM_REGS     = 32,
    parameter logic [7:0] HEADER       = 8'h5A
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trigger,
    input  logic [32*NUM_REGS-1:0]   reg_debug,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     done
);

    localparam int         SNAP_W   = 32 * NUM_REGS;
    localparam logic [15:0] TMR_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  IDX_LAST = 8'(4 * NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         tmr_q, tmr_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          idx_q, idx_d;
    logic                tx_q, tx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic                bit_end;

    assign bit_end = (tmr_q == TMR_LAST);

    // Next-state, bit timing and next line level. The line value is chosen
    // together with the state transition so uart_tx comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        shreg_d   = shreg_q;
        snap_d    = snap_q;
        case (state_q)
            S_IDLE: begin
                tmr_d = 16'd0;
                tx_d  = 1'b1;
                if (trigger) begin
                    state_d   = S_START;
                    snap_d    = reg_debug;
                    shreg_d   = HEADER;
                    bit_cnt_d = 3'd0;
                    idx_d     = 8'd0;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                tmr_d = tmr_q + 16'd1;
                if (bit_end) begin
                    tmr_d   = 16'd0;
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                tmr_d = tmr_q + 16'd1;
                if (bit_end) begin
                    tmr_d = 16'd0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            S_STOP: begin
                tmr_d = tmr_q + 16'd1;
                if (bit_end) begin
                    tmr_d = 16'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FINISH;
                        tx_d    = 1'b1;
                    end else begin
                        // Snapshot is consumed low byte first, so reg0 byte0 leads.
                        state_d   = S_START;
                        shreg_d   = snap_q[7:0];
                        snap_d    = snap_q >> 8;
                        idx_d     = idx_q + 8'd1;
                        bit_cnt_d = 3'd0;
                        tx_d      = 1'b0;
                    end
                end
            end
            S_FINISH: begin
                tmr_d   = 16'd0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Control state with synchronous reset; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tmr_q     <= 16'd0;
            bit_cnt_q <= 3'd0;
            idx_q     <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
        end
    end

    // Datapath registers: byte shifter and register snapshot (no reset needed).
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        snap_q  <= snap_d;
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign done    = (state_q == S_FINISH);

endmodule

// File: tb/tb_reg_dump_uart.sv
// Directed bench for reg_dump_uart with CLKS_PER_BIT=4.
module tb_reg_dump_uart;

    localparam int CPB    = 4;
    localparam int NR     = 32;
    localparam int NBYTES = 1 + 4 * NR;

    logic              clk = 1'b0;
    logic              reset;
    logic              trigger;
    logic [32*NR-1:0]  reg_debug;
    logic              uart_tx;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    logic [31:0] regv  [NR];
    logic [7:0]  exp_b [NBYTES];
    logic [7:0]  rx_b  [160];
    int          rx_n;
    int          tmg_err;
    int          bad_n;
    int          bad_idx;

    reg_dump_uart #(
        .CLKS_PER_BIT(CPB),
        .NUM_REGS    (NR),
        .HEADER      (8'h5A)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .trigger  (trigger),
        .reg_debug(reg_debug),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic step(input int base, input int ra, input int rb);
        tick();
        trigger = ((cyc - base) == ra) || ((cyc - base) == rb);
    endtask

    // Drive regv onto the bus and build the expected byte stream.
    task automatic load_regs();
        exp_b[0] = 8'h5A;
        for (int n = 0; n < NR; n++) begin
            reg_debug[32*n +: 32] = regv[n];
            for (int j = 0; j < 4; j++) exp_b[1 + 4*n + j] = regv[n][8*j +: 8];
        end
    endtask

    task automatic pulse_trigger(output int tcyc);
        trigger = 1'b1;
        tcyc    = cyc;
        tick();
        trigger = 1'b0;
    endtask

    // Record back-to-back bytes cycle by cycle; stops when the line stays
    // high after a stop bit. Optionally pulses trigger at two offsets from base.
    task automatic capture_frame(input int base, input int ra, input int rb);
        logic       s [40];
        logic [7:0] b;
        int         wait_n;
        rx_n = 0; tmg_err = 0; bad_n = 0; bad_idx = -1; wait_n = 0;
        while (uart_tx !== 1'b0 && wait_n < 100) begin
            step(base, ra, rb);
            wait_n++;
        end
        if (uart_tx !== 1'b0) begin
            tmg_err++;
        end else begin
            do begin
                s[0] = uart_tx;
                for (int k = 1; k < 40; k++) begin
                    step(base, ra, rb);
                    s[k] = uart_tx;
                end
                for (int i = 0; i < 8; i++) b[i] = s[4 + 4*i + 2];
                for (int bt = 0; bt < 10; bt++)
                    for (int j = 0; j < 4; j++)
                        if (s[4*bt + j] !== s[4*bt + 2]) tmg_err++;
                if (s[2] !== 1'b0) tmg_err++;
                if (s[38] !== 1'b1) tmg_err++;
                rx_b[rx_n] = b;
                if (rx_n < NBYTES) begin
                    if (b !== exp_b[rx_n]) begin
                        if (bad_n == 0) bad_idx = rx_n;
                        bad_n++;
                    end
                end
                rx_n++;
                step(base, ra, rb);
            end while (uart_tx === 1'b0 && rx_n < 150);
        end
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1; trigger = 1'b0;
        tick(); tick(); tick();
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL idle_line: got %0d non-idle cycles expected 0", bad); end
    endtask

    task automatic test_dump();
        int t; int d0;
        for (int n = 0; n < NR; n++) regv[n] = 32'h1000_0000 + n;
        load_regs();
        d0 = done_cnt;
        pulse_trigger(t);
        checks++; if (busy !== 1'b1 || uart_tx !== 1'b0) begin failures++; $display("FAIL dump_accept: got busy=%b tx=%b expected busy=1 tx=0", busy, uart_tx); end
        capture_frame(t, -1000, -1000);
        checks++; if (rx_n !== NBYTES) begin failures++; $display("FAIL dump_len: got %0d expected %0d", rx_n, NBYTES); end
        checks++; if (bad_n !== 0) begin failures++; $display("FAIL dump_data: byte %0d got %h expected %h", bad_idx, rx_b[bad_idx], exp_b[bad_idx]); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL dump_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++; if (done_cyc - t !== 5161) begin failures++; $display("FAIL dump_done_time: got %0d expected 5161", done_cyc - t); end
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL dump_finish: got busy=%b done=%b expected busy=0 done=1", busy, done); end
    endtask

    task automatic test_snapshot();
        int t;
        for (int n = 0; n < NR; n++) regv[n] = 32'hCAFE_0000 | n;
        load_regs();
        tick();
        pulse_trigger(t);
        reg_debug = '1;
        capture_frame(t, -1000, -1000);
        checks++; if (rx_n !== NBYTES) begin failures++; $display("FAIL snap_len: got %0d expected %0d", rx_n, NBYTES); end
        checks++; if (bad_n !== 0) begin failures++; $display("FAIL snap_data: byte %0d got %h expected %h", bad_idx, rx_b[bad_idx], exp_b[bad_idx]); end
    endtask

    task automatic test_retrigger();
        int t; int t2; int d0;
        for (int n = 0; n < NR; n++) regv[n] = 32'h1000_0000 + n;
        load_regs();
        tick();
        d0 = done_cnt;
        pulse_trigger(t);
        capture_frame(t, 10, 2000);
        checks++; if (rx_n !== NBYTES) begin failures++; $display("FAIL retrig_len: got %0d expected %0d", rx_n, NBYTES); end
        checks++; if (bad_n !== 0) begin failures++; $display("FAIL retrig_data: byte %0d got %h expected %h", bad_idx, rx_b[bad_idx], exp_b[bad_idx]); end
        checks++; if (done_cnt - d0 !== 1 || done !== 1'b1) begin failures++; $display("FAIL retrig_done: got count=%0d done=%b expected count=1 done=1", done_cnt - d0, done); end
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        checks++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin failures++; $display("FAIL trig_on_done: got busy=%b tx=%b expected busy=0 tx=1", busy, uart_tx); end
        pulse_trigger(t2);
        checks++; if (busy !== 1'b1 || uart_tx !== 1'b0) begin failures++; $display("FAIL trig_after_done: got busy=%b tx=%b expected busy=1 tx=0", busy, uart_tx); end
        capture_frame(t2, -1000, -1000);
        checks++; if (rx_n !== NBYTES || bad_n !== 0) begin failures++; $display("FAIL second_frame: got len=%0d bad=%0d expected len=%0d bad=0", rx_n, bad_n, NBYTES); end
    endtask

    task automatic test_reset_abort();
        int t; int d0; int bad;
        for (int n = 0; n < NR; n++) regv[n] = 32'h1000_0000 + n;
        load_regs();
        tick();
        pulse_trigger(t);
        // Byte 7 is reg1 byte2 = 8'h00; land on its data bit 3.
        while (cyc < t + 1 + 7*40 + 4 + 12) tick();
        checks++; if (uart_tx !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre: got tx=%b busy=%b expected tx=0 busy=1", uart_tx, busy); end
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_reset: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, busy); end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0 || done_cnt !== d0) begin failures++; $display("FAIL abort_quiet: got bad=%0d done_pulses=%0d expected 0 and 0", bad, done_cnt - d0); end
        pulse_trigger(t);
        capture_frame(t, -1000, -1000);
        checks++; if (rx_n !== NBYTES || bad_n !== 0 || rx_b[0] !== 8'h5A) begin failures++; $display("FAIL abort_restart: got len=%0d bad=%0d first=%h expected len=%0d bad=0 first=5a", rx_n, bad_n, rx_b[0], NBYTES); end
    endtask

    task automatic test_timing();
        int t;
        for (int n = 0; n < NR; n++) regv[n] = (n % 2 == 1) ? 32'h55AA_F00F : 32'h0FF0_AA55;
        load_regs();
        tick();
        pulse_trigger(t);
        capture_frame(t, -1000, -1000);
        checks++; if (tmg_err !== 0) begin failures++; $display("FAIL bit_timing: got %0d bad samples expected 0", tmg_err); end
        checks++; if (rx_n !== NBYTES) begin failures++; $display("FAIL timing_len: got %0d expected %0d (gap or truncation)", rx_n, NBYTES); end
        checks++; if (bad_n !== 0) begin failures++; $display("FAIL timing_data: byte %0d got %h expected %h", bad_idx, rx_b[bad_idx], exp_b[bad_idx]); end
    endtask

    initial begin
        reset     = 1'b1;
        trigger   = 1'b0;
        reg_debug = '0;
        test_reset();
        test_dump();
        test_snapshot();
        test_retrigger();
        test_reset_abort();
        test_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
